fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage core. Owns the fetch PC and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions in a small prefetch FIFO and presents {instr, pc} to the IF/ID register over a valid/ready handshake.
- Branch redirects from EX flush the FIFO and squash all in-flight responses. Halt freezes request issue.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- DEPTH, 4, prefetch FIFO entries; also the cap on (outstanding requests + buffered entries). Power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid. Responses are in order and cannot be back-pressured.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  taken branch from EX (branch_en && zero).
- redirect_pc  in  XLEN  branch target (PC_E + IM_E).
- halt_fetch  in  1  stop issuing new requests.
- if_valid  out  1  FIFO head valid.
- if_ready  in  1  decode accepts the head.
- if_instr  out  XLEN  head instruction.
- if_pc  out  XLEN  head PC.
- idle  out  1  no outstanding requests and FIFO empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC; pending = 0; drop = 0; FIFO empty.
  - Outputs: if_valid = 0, imem_req_valid = 0 (gated by rst), idle = 1, if_instr = 0, if_pc = 0.
- Reset mid-operation: all state above is cleared. Responses arriving after reset are not counted and are ignored (drop logic only). The memory side must be reset together with this block.
- Request issue (combinational):
  - imem_req_valid = !rst && !halt_fetch && !redirect_valid && (pending + count < DEPTH).
  - imem_req_addr = fetch_pc. Bits [1:0] are always 0.
- Request handshake (req_valid && req_ready):
  - fetch_pc += 4 (mod 2^XLEN; wrap from 0xFFFF_FFFC to 0 is legal).
  - pending += 1.
  - The PC of each issued request is pushed into an internal DEPTH-entry PC tag queue.
- Response (rsp_valid):
  - pending -= 1 and the tag queue pops.
  - If drop > 0 or redirect_valid: discard the response and decrement drop if it is non-zero.
  - Otherwise push {rsp_data, tag_pc} into the FIFO. The credit rule guarantees the FIFO never overflows.
  - Overflow is an assertion failure.
- Output:
  - if_valid = (count != 0). if_instr and if_pc come from the head.
  - The head pops on if_valid && if_ready.
  - No combinational path from imem_rsp to if_*: minimum latency is req handshake → rsp (≥1 cycle) → if_valid the next cycle.
- Redirect (redirect_valid = 1), in the same cycle:
  - No request issued.
  - FIFO and tag queue flushed at the clock edge; the head is not popped even if if_ready = 1.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - drop <= pending - rsp_valid.
  - pending is updated normally.
- Redirect with pending = 0: drop = 0, and fetch restarts the next cycle.
- Back-to-back redirects: the last one wins. drop is recomputed each cycle.
- halt_fetch:
  - Stops new requests only. Outstanding responses still land; decode still drains the FIFO.
  - Deassertion resumes from the current fetch_pc.
- Simultaneous push and pop on the FIFO: count unchanged. This is legal when the FIFO is full and a pop occurs.
- Empty FIFO with if_ready = 1: no pop.
- idle = (pending == 0) && (count == 0).

Test Plan:
- Reset then zero-latency memory (rsp one cycle after req, always ready), if_ready = 1:
  - addrs 0x0, 0x4, 0x8, 0xC issued on consecutive cycles.
  - if_pc sequence 0x0, 0x4, … with matching if_instr.
  - First if_valid 2 cycles after the first request.
- if_ready held at 0, memory always ready:
  - Exactly 4 requests issued (0x0–0xC), then imem_req_valid = 0.
  - FIFO holds 4 entries.
  - Raise if_ready for 1 cycle → one pop, one new request at 0x10.
- 3-cycle memory latency, 3 requests outstanding, redirect_pc = 0x40:
  - The 3 late responses are discarded; none appear on if_*.
  - Next request is at 0x40.
  - The first if_pc after the redirect is 0x40.
- Redirect in the same cycle as rsp_valid and if_valid && if_ready:
  - The response is dropped and the head is not popped (FIFO flushed).
  - drop = pending - 1.
- halt_fetch asserted with 2 outstanding:
  - No further requests.
  - Both responses delivered to if_*; idle = 1 once drained.
  - Deassert → resumes at the next sequential PC.
- Reset asserted with 2 outstanding and 3 buffered:
  - Next cycle if_valid = 0, idle = 1, imem_req_addr = RESET_PC.
  - Stale responses ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited in-order
// requests to instruction memory and buffers responses for decode.

module fetch_unit_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          push_i,
  input logic          pop_i,
  input logic [CW-1:0] count_i,
  input logic [CW-1:0] pending_i,
  input logic [CW-1:0] tcount_i
);
  // FIFO must never overflow; live tags can never exceed outstanding requests
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && !pop_i && (count_i == CW'(DEPTH))));
      assert (tcount_i <= pending_i);
    end
  end
endmodule

module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_fetch,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   pending_q, pending_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   tcount_q, tcount_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0]   twptr_q, twptr_d, trptr_q, trptr_d;

  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] tag_q        [DEPTH];

  logic credit_ok_s;
  logic req_fire_s;
  logic rsp_fire_s;
  logic rsp_keep_s;
  logic push_s;
  logic pop_s;
  logic redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // A response seen with nothing outstanding is a leftover from before reset
  assign credit_ok_s    = ({1'b0, pending_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && !halt_fetch && !redirect_valid && credit_ok_s;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign rsp_fire_s     = imem_rsp_valid && (pending_q != '0);
  assign rsp_keep_s     = rsp_fire_s && !redirect_valid && (drop_q == '0);
  assign push_s         = rsp_keep_s;
  assign pop_s          = if_valid && if_ready && !redirect_valid;

  assign if_valid = (count_q != '0);
  assign if_instr = if_valid ? fifo_instr_q[rptr_q] : '0;
  assign if_pc    = if_valid ? fifo_pc_q[rptr_q]    : '0;
  assign idle     = (pending_q == '0) && (count_q == '0);

  // Next-state: redirect flushes both queues and converts in-flight requests into drops
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    twptr_d    = twptr_q;
    trptr_d    = trptr_q;
    tcount_d   = tcount_q;
    pending_d  = pending_q + CW'(req_fire_s) - CW'(rsp_fire_s);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d     = pending_q - CW'(rsp_fire_s);
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      twptr_d    = '0;
      trptr_d    = '0;
      tcount_d   = '0;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_fire_s && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
      wptr_d   = wptr_q + AW'(push_s);
      rptr_d   = rptr_q + AW'(pop_s);
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      // Dropped responses never had a live tag, so only kept ones pop the tag queue
      twptr_d  = twptr_q + AW'(req_fire_s);
      trptr_d  = trptr_q + AW'(rsp_keep_s);
      tcount_d = tcount_q + CW'(req_fire_s) - CW'(rsp_keep_s);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pending_q  <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      tcount_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      twptr_q    <= '0;
      trptr_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      tcount_q   <= tcount_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      twptr_q    <= twptr_d;
      trptr_q    <= trptr_d;
    end
  end

  // Data storage; contents are only observed through valid pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_instr_q[wptr_q] <= imem_rsp_data;
      fifo_pc_q[wptr_q]    <= tag_q[trptr_q];
    end
    if (req_fire_s) begin
      tag_q[twptr_q] <= fetch_pc_q;
    end
  end

  fetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk_i     (clk),
    .rst_i     (rst),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .count_i   (count_q),
    .pending_i (pending_q),
    .tcount_i  (tcount_q)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order memory model;
// memory returns ~addr as the instruction word.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_fetch;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        idle;

  int n_tests;
  int n_fail;
  int cycle;
  int mem_lat;
  bit mem_reset_en;
  int          mem_due  [$];
  logic [31:0] mem_data [$];
  logic [31:0] issued   [$];
  logic [31:0] got_pc   [$];
  logic [31:0] got_instr[$];

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_fetch     (halt_fetch),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes before the edge, then advance the memory model
  task automatic tick();
    logic        fired;
    logic [31:0] a;
    #1;
    fired = imem_req_valid && imem_req_ready;
    a     = imem_req_addr;
    if (fired) issued.push_back(a);
    if (if_valid && if_ready && !redirect_valid && !rst) begin
      got_pc.push_back(if_pc);
      got_instr.push_back(if_instr);
    end
    @(posedge clk);
    #1;
    cycle++;
    if (rst && mem_reset_en) begin
      mem_due.delete();
      mem_data.delete();
    end else if (fired) begin
      mem_due.push_back(cycle + mem_lat - 1);
      mem_data.push_back(~a);
    end
    if (mem_due.size() > 0 && mem_due[0] <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data[0];
      void'(mem_due.pop_front());
      void'(mem_data.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    halt_fetch = 1'b0;
    if_ready = 1'b0;
    mem_reset_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cycle = 0;
    issued.delete();
    got_pc.delete();
    got_instr.delete();
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cycle = 0; mem_lat = 1; mem_reset_en = 1'b1;
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt_fetch = 1'b0; if_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_req_gated", {31'h0, imem_req_valid}, 32'h0);

    // Reset state
    do_reset();
    check_eq("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check_eq("rst_idle", {31'h0, idle}, 32'h1);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_instr", if_instr, 32'h0);
    check_eq("rst_addr", imem_req_addr, 32'h0);

    // Zero-latency memory, decode always ready
    mem_lat = 1; if_ready = 1'b1; #1;
    check_eq("t1_req0", {31'h0, imem_req_valid}, 32'h1);
    tick();
    check_eq("t1_lat1", {31'h0, if_valid}, 32'h0);
    tick();
    check_eq("t1_lat2", {31'h0, if_valid}, 32'h1);
    check_eq("t1_pc0", if_pc, 32'h0);
    check_eq("t1_instr0", if_instr, 32'hFFFF_FFFF);
    repeat (6) tick();
    check_eq("t1_iss0", issued[0], 32'h0);
    check_eq("t1_iss1", issued[1], 32'h4);
    check_eq("t1_iss2", issued[2], 32'h8);
    check_eq("t1_iss3", issued[3], 32'hC);
    check_eq("t1_got1", got_pc[1], 32'h4);
    check_eq("t1_ins1", got_instr[1], 32'hFFFF_FFFB);
    check_eq("t1_got3", got_pc[3], 32'hC);

    // Decode stalled: credit caps issue at DEPTH
    do_reset();
    mem_lat = 1; #1;
    repeat (8) tick();
    check_eq("t2_nissued", issued.size(), 32'd4);
    check_eq("t2_iss3", issued[3], 32'hC);
    check_eq("t2_req_stop", {31'h0, imem_req_valid}, 32'h0);
    check_eq("t2_head", if_pc, 32'h0);
    check_eq("t2_idle", {31'h0, idle}, 32'h0);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0; #1;
    check_eq("t2_one_pop", got_pc.size(), 32'd1);
    check_eq("t2_pop_pc", got_pc[0], 32'h0);
    check_eq("t2_req_again", {31'h0, imem_req_valid}, 32'h1);
    check_eq("t2_addr10", imem_req_addr, 32'h10);
    tick();
    if_ready = 1'b1;
    repeat (6) tick();
    check_eq("t2_drain1", got_pc[1], 32'h4);
    check_eq("t2_drain3", got_pc[3], 32'hC);
    check_eq("t2_drain4", got_pc[4], 32'h10);

    // Redirect with 3 outstanding on slow memory
    do_reset();
    mem_lat = 4; if_ready = 1'b1; #1;
    repeat (3) tick();
    check_eq("t3_outst", issued.size(), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0042; #1;
    check_eq("t3_no_req", {31'h0, imem_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0; #1;
    check_eq("t3_addr40", imem_req_addr, 32'h40);
    check_eq("t3_req", {31'h0, imem_req_valid}, 32'h1);
    repeat (12) tick();
    check_eq("t3_first_pc", got_pc[0], 32'h40);
    check_eq("t3_first_ins", got_instr[0], 32'hFFFF_FFBF);
    check_eq("t3_second_pc", got_pc[1], 32'h44);

    // Redirect coincides with a response and a decode handshake
    do_reset();
    mem_lat = 2; if_ready = 1'b1; #1;
    repeat (3) tick();
    check_eq("t4_pre_valid", {31'h0, if_valid}, 32'h1);
    check_eq("t4_pre_pc", if_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
    tick();
    redirect_valid = 1'b0; #1;
    check_eq("t4_flushed", {31'h0, if_valid}, 32'h0);
    check_eq("t4_no_pop", got_pc.size(), 32'd0);
    check_eq("t4_addr", imem_req_addr, 32'h100);
    repeat (8) tick();
    check_eq("t4_first_pc", got_pc[0], 32'h100);
    check_eq("t4_first_ins", got_instr[0], 32'hFFFF_FEFF);

    // Halt with 2 outstanding
    do_reset();
    mem_lat = 3; if_ready = 1'b1; #1;
    repeat (2) tick();
    halt_fetch = 1'b1; #1;
    check_eq("t5_halt_req", {31'h0, imem_req_valid}, 32'h0);
    repeat (6) tick();
    check_eq("t5_nissued", issued.size(), 32'd2);
    check_eq("t5_ngot", got_pc.size(), 32'd2);
    check_eq("t5_got0", got_pc[0], 32'h0);
    check_eq("t5_got1", got_pc[1], 32'h4);
    check_eq("t5_idle", {31'h0, idle}, 32'h1);
    halt_fetch = 1'b0; #1;
    check_eq("t5_resume", {31'h0, imem_req_valid}, 32'h1);
    check_eq("t5_resume_addr", imem_req_addr, 32'h8);

    // Reset mid-flight; memory keeps one stale response to be ignored
    do_reset();
    mem_lat = 3; #1;
    repeat (5) tick();
    check_eq("t6_pre_valid", {31'h0, if_valid}, 32'h1);
    check_eq("t6_pre_idle", {31'h0, idle}, 32'h0);
    rst = 1'b1; halt_fetch = 1'b1; mem_reset_en = 1'b0;
    tick();
    rst = 1'b0; #1;
    check_eq("t6_valid", {31'h0, if_valid}, 32'h0);
    check_eq("t6_idle", {31'h0, idle}, 32'h1);
    check_eq("t6_addr", imem_req_addr, 32'h0);
    repeat (3) tick();
    check_eq("t6_stale_valid", {31'h0, if_valid}, 32'h0);
    check_eq("t6_stale_idle", {31'h0, idle}, 32'h1);
    mem_reset_en = 1'b1; halt_fetch = 1'b0; if_ready = 1'b1;
    issued.delete(); got_pc.delete(); got_instr.delete(); #1;
    repeat (6) tick();
    check_eq("t6_restart_iss", issued[0], 32'h0);
    check_eq("t6_restart_pc", got_pc[0], 32'h0);
    check_eq("t6_restart_ins", got_instr[0], 32'hFFFF_FFFF);

    // PC wrap at the top of the address space
    do_reset();
    mem_lat = 1; if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
    tick();
    redirect_valid = 1'b0; #1;
    repeat (6) tick();
    check_eq("t7_iss0", issued[0], 32'hFFFF_FFF8);
    check_eq("t7_iss1", issued[1], 32'hFFFF_FFFC);
    check_eq("t7_iss2", issued[2], 32'h0);
    check_eq("t7_got1", got_pc[1], 32'hFFFF_FFFC);
    check_eq("t7_ins1", got_instr[1], 32'h0000_0003);
    check_eq("t7_got2", got_pc[2], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
